// File: rtl/mm_pkg.sv
// Shared types and elaboration helpers for the tiled matrix-multiply datapath.
// Width helpers never return 0 so single-element dimensions still get a 1-bit port.
package mm_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FEED,
      DRAIN,
      DONE
   } state_t;

   function automatic int clog2_min1(input int v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

   function automatic int aw_a(input int mr, input int n1, input int mk);
      return clog2_min1((mr / n1) * mk);
   endfunction

   function automatic int aw_b(input int mc, input int n2, input int mk);
      return clog2_min1((mc / n2) * mk);
   endfunction

   function automatic int tile_row_w(input int mr, input int n1);
      return clog2_min1(mr / n1);
   endfunction

   function automatic int tile_col_w(input int mc, input int n2);
      return clog2_min1(mc / n2);
   endfunction

   function automatic bit params_ok(input int d_w, input int d_w_acc, input int n1,
                                    input int n2, input int mr, input int mk,
                                    input int mc, input int drain_cyc);
      return (d_w >= 1) && (d_w_acc >= d_w) && (n1 >= 1) && (n2 >= 1) &&
             (mr >= n1) && (mc >= n2) && (mr % n1 == 0) && (mc % n2 == 0) &&
             (mk >= 1) && (drain_cyc >= 0);
   endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MOD counter with synchronous clear and a wrap flag for chaining.
// o_wrap is only asserted on an enabled cycle, so it can drive the next stage's enable.
module wrap_counter
   import mm_pkg::*;
#(
   parameter int MOD = 2,
   parameter int W   = clog2_min1(MOD)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_cnt,
   output logic         o_wrap
);

   localparam logic [W-1:0] MAX_CNT = W'(MOD - 1);

   logic [W-1:0] r_cnt;

   assign o_wrap = i_en && (r_cnt == MAX_CNT);
   assign o_cnt  = r_cnt;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_en)
         r_cnt <= o_wrap ? '0 : r_cnt + W'(1);
   end

endmodule

// File: rtl/mm_tile_sequencer.sv
// Read-side sequencer: walks r/c/k tiles, issues A/B bank addresses and
// flags the first/last inner-product step of each output tile.
module mm_tile_sequencer
   import mm_pkg::*;
#(
   parameter  int D_W       = 8,
   parameter  int D_W_ACC   = 16,
   parameter  int N1        = 4,
   parameter  int N2        = 4,
   parameter  int MR        = 8,
   parameter  int MK        = 8,
   parameter  int MC        = 8,
   parameter  int DRAIN_CYC = N1 + N2,
   localparam int AW_A      = aw_a(MR, N1, MK),
   localparam int AW_B      = aw_b(MC, N2, MK),
   localparam int TRW       = tile_row_w(MR, N1),
   localparam int TCW       = tile_col_w(MC, N2)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            stall,
   output logic            busy,
   output logic            done,
   output logic            rd_en,
   output logic [AW_A-1:0] rd_addr_A,
   output logic [AW_B-1:0] rd_addr_B,
   output logic            k_first,
   output logic            k_last,
   output logic [TRW-1:0]  tile_row,
   output logic [TCW-1:0]  tile_col
);

   localparam int KW  = clog2_min1(MK);
   localparam int DCW = clog2_min1(DRAIN_CYC);

   localparam logic [KW-1:0]   K_MAX  = KW'(MK - 1);
   localparam logic [AW_A-1:0] MK_A   = AW_A'(MK);
   localparam logic [AW_B-1:0] MK_B   = AW_B'(MK);
   localparam logic [DCW-1:0]  D_LAST = DCW'(DRAIN_CYC - 1);

   if (!params_ok(D_W, D_W_ACC, N1, N2, MR, MK, MC, DRAIN_CYC)) begin : g_param_check
      $error("mm_tile_sequencer: MR/MC must be multiples of N1/N2 and MK >= 1");
   end

   state_t           r_state;
   state_t           w_next;
   logic [DCW-1:0]   r_drain_cnt;
   logic             w_issue;
   logic             w_clr;
   logic             w_drain_end;
   logic [KW-1:0]    w_k_cnt;
   logic [TCW-1:0]   w_c_cnt;
   logic [TRW-1:0]   w_r_cnt;
   logic             w_k_wrap;
   logic             w_c_wrap;
   logic             w_r_wrap;

   assign w_issue     = (r_state == FEED) && !stall;
   assign w_clr       = (r_state == IDLE);
   assign w_drain_end = (DRAIN_CYC == 0) || (r_drain_cnt == D_LAST);

   // k is innermost; each stage advances only when the one below wraps.
   wrap_counter #(.MOD(MK), .W(KW)) u_k_cnt (
      .clk(clk), .rst(rst), .i_clr(w_clr), .i_en(w_issue),
      .o_cnt(w_k_cnt), .o_wrap(w_k_wrap)
   );

   wrap_counter #(.MOD(MC / N2), .W(TCW)) u_c_cnt (
      .clk(clk), .rst(rst), .i_clr(w_clr), .i_en(w_k_wrap),
      .o_cnt(w_c_cnt), .o_wrap(w_c_wrap)
   );

   wrap_counter #(.MOD(MR / N1), .W(TRW)) u_r_cnt (
      .clk(clk), .rst(rst), .i_clr(w_clr), .i_en(w_c_wrap),
      .o_cnt(w_r_cnt), .o_wrap(w_r_wrap)
   );

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (rst || (r_state != DRAIN))
         r_drain_cnt <= '0;
      else
         r_drain_cnt <= r_drain_cnt + DCW'(1);
   end

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      w_next  = r_state;
      busy    = 1'b0;
      done    = 1'b0;
      rd_en   = 1'b0;
      k_first = 1'b0;
      k_last  = 1'b0;
      case (r_state)
         IDLE: begin
            if (start)
               w_next = FEED;
         end
         FEED: begin
            busy    = 1'b1;
            rd_en   = !stall;
            k_first = !stall && (w_k_cnt == '0);
            k_last  = !stall && (w_k_cnt == K_MAX);
            if (w_r_wrap)
               w_next = (DRAIN_CYC == 0) ? DONE : DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (w_drain_end)
               w_next = DONE;
         end
         DONE: begin
            done   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign rd_addr_A = AW_A'(w_r_cnt) * MK_A + AW_A'(w_k_cnt);
   assign rd_addr_B = AW_B'(w_c_cnt) * MK_B + AW_B'(w_k_cnt);
   assign tile_row  = w_r_cnt;
   assign tile_col  = w_c_cnt;

endmodule

// File: tb/tb_mm_tile_sequencer.sv
// Directed bench for mm_tile_sequencer: nominal, stall, MK=1, ignored start,
// mid-run reset and a non-square tiling, each on its own parameterised instance.
module tb_mm_tile_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic start0, stall0, start1, start2, stall_off;

   // nominal: N1=N2=2, MR=MC=4, MK=3
   logic       busy0, done0, rd_en0, kf0, kl0, tr0, tc0;
   logic [2:0] a0, b0;
   // single tile: N1=N2=2, MR=MC=2, MK=1
   logic       busy1, done1, rd_en1, kf1, kl1, tr1, tc1, a1, b1;
   // non-square: N1=2, N2=4, MR=2, MC=8, MK=2
   logic       busy2, done2, rd_en2, kf2, kl2, tr2, tc2, a2;
   logic [1:0] b2;

   mm_tile_sequencer #(.N1(2), .N2(2), .MR(4), .MK(3), .MC(4)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .stall(stall0),
      .busy(busy0), .done(done0), .rd_en(rd_en0),
      .rd_addr_A(a0), .rd_addr_B(b0), .k_first(kf0), .k_last(kl0),
      .tile_row(tr0), .tile_col(tc0)
   );

   mm_tile_sequencer #(.N1(2), .N2(2), .MR(2), .MK(1), .MC(2)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .stall(stall_off),
      .busy(busy1), .done(done1), .rd_en(rd_en1),
      .rd_addr_A(a1), .rd_addr_B(b1), .k_first(kf1), .k_last(kl1),
      .tile_row(tr1), .tile_col(tc1)
   );

   mm_tile_sequencer #(.N1(2), .N2(4), .MR(2), .MK(2), .MC(8)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .stall(stall_off),
      .busy(busy2), .done(done2), .rd_en(rd_en2),
      .rd_addr_A(a2), .rd_addr_B(b2), .k_first(kf2), .k_last(kl2),
      .tile_row(tr2), .tile_col(tc2)
   );

   int total = 0;
   int bad   = 0;

   int exp_a[12]  = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
   int exp_b[12]  = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};
   int ns_a[4]    = '{0, 1, 0, 1};
   int ns_b[4]    = '{0, 1, 2, 3};
   int ns_col[4]  = '{0, 0, 1, 1};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Lands 1 time unit after a rising edge: drive inputs, then #1 before sampling.
   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic run_nominal(input string tag);
      int n;
      next_cyc(); start0 = 1'b1; #1;
      next_cyc(); start0 = 1'b0; #1;
      n = 1;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) begin
            next_cyc(); #1;
            n++;
         end
         check({tag, "_rd_en"},   rd_en0, 1);
         check({tag, "_addr_a"},  a0, exp_a[i]);
         check({tag, "_addr_b"},  b0, exp_b[i]);
         check({tag, "_k_first"}, kf0, (i % 3 == 0));
         check({tag, "_k_last"},  kl0, (i % 3 == 2));
      end
      next_cyc(); #1;
      n++;
      check({tag, "_drain_rd_en"}, rd_en0, 0);
      check({tag, "_drain_busy"},  busy0, 1);
      while (!done0 && n < 40) begin
         next_cyc(); #1;
         n++;
      end
      check({tag, "_done_seen"},    done0, 1);
      check({tag, "_done_latency"}, n, 17);
      check({tag, "_busy_in_done"}, busy0, 0);
      next_cyc(); #1;
      check({tag, "_done_pulse"}, done0, 0);
   endtask

   initial begin
      int n, issues, dones, done_at;
      rst = 1'b1; start0 = 1'b0; stall0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      stall_off = 1'b0;

      // reset values
      next_cyc(); next_cyc(); #1;
      check("rst_busy",  busy0, 0);
      check("rst_done",  done0, 0);
      check("rst_rd_en", rd_en0, 0);
      check("rst_kf",    kf0, 0);
      check("rst_kl",    kl0, 0);
      check("rst_a",     a0, 0);
      check("rst_b",     b0, 0);
      check("rst_row",   tr0, 0);
      check("rst_col",   tc0, 0);
      next_cyc(); rst = 1'b0; #1;

      // nominal run
      run_nominal("nom");

      // stall 3 cycles at k=1 of the first tile
      next_cyc(); start0 = 1'b1; #1;
      next_cyc(); start0 = 1'b0; #1;
      n = 1;
      check("stl_issue0_rd_en", rd_en0, 1);
      check("stl_issue0_a",     a0, 0);
      for (int s = 0; s < 3; s++) begin
         next_cyc(); stall0 = 1'b1; #1;
         n++;
         check("stl_rd_en", rd_en0, 0);
         check("stl_kf",    kf0, 0);
         check("stl_a",     a0, 1);
         check("stl_b",     b0, 1);
      end
      for (int i = 1; i < 12; i++) begin
         next_cyc(); stall0 = 1'b0; #1;
         n++;
         check("stl_resume_rd_en", rd_en0, 1);
         check("stl_resume_a",     a0, exp_a[i]);
         check("stl_resume_b",     b0, exp_b[i]);
      end
      while (!done0 && n < 40) begin
         next_cyc(); #1;
         n++;
      end
      check("stl_done_latency", n, 20);
      next_cyc(); #1;

      // MK=1 single tile
      next_cyc(); start1 = 1'b1; #1;
      next_cyc(); start1 = 1'b0; #1;
      n = 1;
      check("mk1_rd_en", rd_en1, 1);
      check("mk1_kf",    kf1, 1);
      check("mk1_kl",    kl1, 1);
      check("mk1_a",     a1, 0);
      check("mk1_b",     b1, 0);
      check("mk1_row",   tr1, 0);
      check("mk1_col",   tc1, 0);
      next_cyc(); #1;
      n++;
      check("mk1_drain_rd_en", rd_en1, 0);
      check("mk1_drain_busy",  busy1, 1);
      while (!done1 && n < 40) begin
         next_cyc(); #1;
         n++;
      end
      check("mk1_done_latency", n, 6);
      next_cyc(); #1;

      // start during FEED (cycle 5) and DRAIN (cycle 14) is ignored
      next_cyc(); start0 = 1'b1; #1;
      issues = 0; dones = 0; done_at = 0;
      for (int c = 1; c <= 30; c++) begin
         next_cyc();
         start0 = (c == 5) || (c == 14);
         #1;
         if (rd_en0) issues++;
         if (done0) begin
            dones++;
            done_at = c;
         end
      end
      check("ign_issues",  issues, 12);
      check("ign_dones",   dones, 1);
      check("ign_done_at", done_at, 17);
      check("ign_idle",    busy0, 0);

      // reset at issue 5 abandons the multiply
      next_cyc(); start0 = 1'b1; #1;
      for (int c = 1; c <= 6; c++) begin
         next_cyc();
         start0 = 1'b0;
         rst    = (c == 6);
         #1;
         if (c == 6) begin
            check("rst5_a_before", a0, 2);
            check("rst5_b_before", b0, 5);
         end
      end
      next_cyc(); rst = 1'b0; #1;
      check("rst5_busy",  busy0, 0);
      check("rst5_rd_en", rd_en0, 0);
      check("rst5_done",  done0, 0);
      check("rst5_kf",    kf0, 0);
      check("rst5_kl",    kl0, 0);
      check("rst5_a",     a0, 0);
      check("rst5_b",     b0, 0);
      check("rst5_row",   tr0, 0);
      check("rst5_col",   tc0, 0);
      dones = 0;
      for (int c = 0; c < 20; c++) begin
         next_cyc(); #1;
         if (done0) dones++;
      end
      check("rst5_no_done", dones, 0);
      run_nominal("rerun");

      // non-square tiling
      next_cyc(); start2 = 1'b1; #1;
      next_cyc(); start2 = 1'b0; #1;
      n = 1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            next_cyc(); #1;
            n++;
         end
         check("ns_rd_en", rd_en2, 1);
         check("ns_a",     a2, ns_a[i]);
         check("ns_b",     b2, ns_b[i]);
         check("ns_col",   tc2, ns_col[i]);
         check("ns_row",   tr2, 0);
         check("ns_kf",    kf2, (i % 2 == 0));
         check("ns_kl",    kl2, (i % 2 == 1));
      end
      while (!done2 && n < 40) begin
         next_cyc(); #1;
         n++;
      end
      check("ns_done_latency", n, 11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mm_tile_sequencer.md
# mm_tile_sequencer

Read-side sequencer for the tiled matrix-multiply datapath. It is the generalised successor of the square-matrix array controller. It supports:
- non-square operands: A is MR×MK, B is MK×MC;
- a start/done handshake;
- a stall input that freezes issue;
- tile-boundary flags for the PE accumulators.

It sits between the A/B operand bank memories and the N1×N2 systolic array. Every cycle it issues one bank address per operand and marks the first and last inner-product step of each output tile.

## Interface
- D_W, 8, operand width (passed through for package consistency; no datapath here)
- D_W_ACC, 16, accumulator width (passed through)
- N1, 4, array rows; A bank count
- N2, 4, array columns; B bank count
- MR, 8, rows of A; must be a multiple of N1
- MK, 8, inner dimension; must be ≥1
- MC, 8, columns of B; must be a multiple of N2
- DRAIN_CYC, N1+N2, cycles after the last issue before done
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a full multiply; sampled only in IDLE
- stall  in  1  hold issue; counters freeze
- busy  out  1  high in FEED and DRAIN
- done  out  1  one-cycle pulse when the multiply completes
- rd_en  out  1  read strobe, shared by all A and B banks
- rd_addr_A  out  AW_A=max(1,clog2((MR/N1)*MK))  address into every A bank
- rd_addr_B  out  AW_B=max(1,clog2((MC/N2)*MK))  address into every B bank
- k_first  out  1  current issue is k=0 of a tile; PE clears its accumulator
- k_last  out  1  current issue is k=MK-1; tile result complete after skew
- tile_row  out  max(1,clog2(MR/N1))  row-slice index of the current issue
- tile_col  out  max(1,clog2(MC/N2))  column-slice index of the current issue

## Operation
- **Bank layout.**
  - A bank i holds rows i, i+N1, …, row-major in k.
  - B bank j holds columns j, j+N2, …, in k order.
- **Address mapping.**
  - rd_addr_A = r*MK + k.
  - rd_addr_B = c*MK + k.
- **Loop order.**
  - k is the inner loop (0..MK-1).
  - c is the middle loop (0..MC/N2-1).
  - r is the outer loop (0..MR/N1-1).
  - Total issues: (MR/N1)*(MC/N2)*MK.
- **FSM states:** IDLE, FEED, DRAIN, DONE.
  - IDLE→FEED on start. Counters r, c, k are cleared on entry.
  - FEED: each non-stalled cycle issues one read and advances k. k wraps to 0 and increments c; c wraps to 0 and increments r.
  - FEED→DRAIN after the issue with r, c, k all at their maximum.
  - DRAIN counts DRAIN_CYC cycles, then goes to DONE. If DRAIN_CYC=0, it goes straight to DONE.
  - DONE lasts one cycle, then IDLE.
- **Output decode.**
  - rd_en = (state==FEED) && !stall.
  - k_first and k_last are qualified by rd_en. They are low whenever rd_en is low.
  - tile_row, tile_col and both addresses always reflect the current counters.
- **Stall.**
  - Effective only in FEED. Counters hold and rd_en=0.
  - Ignored in DRAIN, which continues to count.
- **Start handling.**
  - start in any state other than IDLE is ignored and is not queued.
  - start held high continuously restarts a new multiply on each return to IDLE.
- **Degenerate sizes.**
  - MK=1: k_first and k_last are both high on every issue.
  - MR=N1 and MC=N2: a single tile.
- **Reset.** rst in any state returns to IDLE next edge and clears all counters. An in-flight multiply is abandoned; no done is produced.

## Timing
- Reset values:
  - busy=0, done=0, rd_en=0, k_first=0, k_last=0;
  - rd_addr_A=0, rd_addr_B=0, tile_row=0, tile_col=0.
- start sampled high at edge t → FEED from edge t; first rd_en in cycle t+1 with addresses 0/0 and k_first=1.
- Absent stall, rd_en is continuous for all issues. The last issue is followed by DRAIN_CYC DRAIN cycles, then the done pulse.
- Latency from start to done: issues + stalls + DRAIN_CYC + 1 cycles.
- busy=0 in the done cycle.
- Bank read data is expected one cycle after rd_en. The array applies row/column skew downstream; this block does not skew.

## Structure
- Shared package `mm_pkg`:
  - state enum {IDLE, FEED, DRAIN, DONE};
  - width functions for AW_A, AW_B, tile_row and tile_col, each with max(1, clog2) guarding;
  - elaboration-time parameter legality checks: MR%N1==0, MC%N2==0, MK≥1.
- One natural sub-module, `wrap_counter`:
  - parameterised modulus;
  - enable, clear and wrap outputs;
  - instantiated three times, chained for k→c→r.

## Test plan
- Nominal run (N1=N2=2, MR=MC=4, MK=3), start pulse → 12 contiguous rd_en.
  - rd_addr_A sequence 0,1,2,0,1,2,3,4,5,3,4,5.
  - rd_addr_B sequence 0,1,2,3,4,5,0,1,2,3,4,5.
  - k_first on issues 0,3,6,9.
  - done exactly 12+4+1 cycles after start.
- Stall for 3 cycles mid-tile at k=1 → rd_en low 3 cycles, addresses held, sequence resumes at k=1, done delayed by exactly 3.
- MK=1 with MR=N1, MC=N2 → single issue with k_first=k_last=1, addresses 0/0, done after DRAIN_CYC+1.
- start asserted during FEED and during DRAIN → ignored; issue count unchanged; a single done.
- rst asserted at issue 5 → next cycle busy=0, rd_en=0, all outputs 0, no done. A fresh start then replays the full sequence from address 0.
- Non-square (N1=2, N2=4, MR=2, MC=8, MK=2) → tile_col 0,0,1,1; rd_addr_B 0,1,2,3; rd_addr_A 0,1,0,1.
